// File: rtl/rca_operand_fifo.sv
// Operand-pair FWFT queue feeding the 16-bit ripple-carry adder.
// Ports: clk/rst, in_valid/in_ready/in_a/in_b, out_valid/out_ready/out_a/out_b, count, overflow.
module rca_operand_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PONE = AW'(1);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [CW-1:0] CFULL = CW'(DEPTH);

  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;

  logic               w_push;
  logic               w_pop;
  logic [2*WIDTH-1:0] w_head;

  assign in_ready  = (r_count != CFULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_head    = r_mem[r_rptr];

  // Empty queue drives zeros so the adder sees a clean 0 + 0.
  assign out_a    = out_valid ? w_head[2*WIDTH-1:WIDTH] : '0;
  assign out_b    = out_valid ? w_head[WIDTH-1:0]       : '0;
  assign count    = r_count;
  assign overflow = r_overflow;

  // Storage is never cleared; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wptr] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PONE;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CONE;
        2'b01:   r_count <= r_count - CONE;
        default: r_count <= r_count;
      endcase
      // Sticky: only reset clears it.
      if (in_valid && !in_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
